// File: rtl/pixel_sink_if.sv
// Pixel-plot bus from the main datapath plus the stallable framebuffer write port.
// pixel_sink uses the slave view; whatever drives plots and accepts writes uses master.
interface pixel_sink_if;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_write;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_write;
  logic        fb_ready;

  modport master (
    output vga_x, vga_y, vga_colour, vga_write, fb_ready,
    input  fb_addr, fb_data, fb_write
  );

  modport slave (
    input  vga_x, vga_y, vga_colour, vga_write, fb_ready,
    output fb_addr, fb_data, fb_write
  );
endinterface

// File: rtl/pixel_sink.sv
// Clips pixel plots, queues them in a small FIFO and writes them to a stallable
// framebuffer port; also sweeps a full-screen clear on a start/done pulse handshake.
module pixel_sink #(
  parameter int         WIDTH        = 160,
  parameter int         HEIGHT       = 120,
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
  input  logic         clock,
  input  logic         reset,
  pixel_sink_if.slave  bus,
  input  logic         clear_start,
  output logic         clear_done,
  output logic         fifo_full,
  output logic         overflow,
  output logic [15:0]  pixel_count
);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR, DONE} state_t;

  typedef struct packed {
    logic [14:0] addr;
    logic [2:0]  colour;
  } pixel_t;

  localparam int              PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [14:0]     LAST_ADDR  = 15'(WIDTH * HEIGHT - 1);

  pixel_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  pixel_t           out_reg;
  logic             out_valid;
  logic [14:0]      clear_addr;
  state_t           state, state_next;

  logic        in_range, push, pop, accept;
  logic [14:0] plot_addr;

  assign in_range  = (int'(bus.vga_x) < WIDTH) && (int'(bus.vga_y) < HEIGHT);
  assign fifo_full = (count == FULL_COUNT);
  assign push      = bus.vga_write && in_range && !fifo_full;
  assign accept    = bus.fb_write && bus.fb_ready;
  // A push into an empty FIFO is only visible through count on the next edge.
  assign pop       = (state == IDLE) && (count != '0) && (!out_valid || accept);
  assign plot_addr = 15'(bus.vga_y) * 15'(WIDTH) + 15'(bus.vga_x);

  // The sweep owns the write port for the whole of CLEAR; the plot register is empty then.
  assign bus.fb_write = (state == CLEAR) || out_valid;
  assign bus.fb_addr  = (state == CLEAR) ? clear_addr   : out_reg.addr;
  assign bus.fb_data  = (state == CLEAR) ? CLEAR_COLOUR : out_reg.colour;

  // NOTE: FIFO storage has no reset; the pointers and count alone define what is valid,
  // which keeps the array a plain RAM without a reset fan-out to every entry.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= '{addr: plot_addr, colour: bus.vga_colour};
  end

  // NOTE: state registers use non-blocking assignments only, so every flop samples
  // the pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_reg     <= '0;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
      pixel_count <= '0;
      clear_addr  <= '0;
      state       <= IDLE;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (pop) begin
        out_reg   <= mem[rd_ptr];
        out_valid <= 1'b1;
      end else if (accept && state != CLEAR) begin
        out_valid <= 1'b0;
      end

      if (bus.vga_write && in_range && fifo_full) overflow <= 1'b1;
      if (accept && state != CLEAR) pixel_count <= pixel_count + 16'd1;

      if (state == CLEAR && accept)
        clear_addr <= (clear_addr == LAST_ADDR) ? 15'd0 : clear_addr + 15'd1;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    clear_done = 1'b0;
    case (state)
      IDLE:  if (clear_start) state_next = DRAIN;
      // Popping is paused; leave once the last in-flight plot has been accepted.
      DRAIN: if (!out_valid || accept) state_next = CLEAR;
      CLEAR: if (accept && clear_addr == LAST_ADDR) state_next = DONE;
      DONE: begin
        clear_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pixel_sink.sv
// Self-checking bench for pixel_sink: directed scenarios plus a randomized run
// scored against a queue model of the plots that should reach the framebuffer.
module tb_pixel_sink;

  localparam int WIDTH      = 160;
  localparam int HEIGHT     = 120;
  localparam int FIFO_DEPTH = 8;
  localparam int SCREEN     = WIDTH * HEIGHT;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear_start;
  logic        clear_done;
  logic        fifo_full;
  logic        overflow;
  logic [15:0] pixel_count;

  int vectors    = 0;
  int miscompares = 0;

  pixel_sink_if bus ();

  pixel_sink #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .FIFO_DEPTH(FIFO_DEPTH), .CLEAR_COLOUR(3'b000)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .clear_start (clear_start),
    .clear_done  (clear_done),
    .fifo_full   (fifo_full),
    .overflow    (overflow),
    .pixel_count (pixel_count)
  );

  always #5 clock = ~clock;

  // Drive one cycle of inputs after the falling edge, then observe the write port.
  task automatic step(input logic pv, input logic [7:0] x, input logic [6:0] y,
                      input logic [2:0] c, input logic rdy, input logic clr,
                      output logic w, output logic [14:0] a, output logic [2:0] d);
    @(negedge clock);
    bus.vga_write  = pv;
    bus.vga_x      = x;
    bus.vga_y      = y;
    bus.vga_colour = c;
    bus.fb_ready   = rdy;
    clear_start    = clr;
    #1;
    w = bus.fb_write;
    a = bus.fb_addr;
    d = bus.fb_data;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset          = 1'b1;
    bus.vga_write  = 1'b0;
    bus.vga_x      = '0;
    bus.vga_y      = '0;
    bus.vga_colour = '0;
    bus.fb_ready   = 1'b0;
    clear_start    = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    vectors++;
    if ({bus.fb_write, bus.fb_addr, bus.fb_data} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_fb: got write=%0d addr=%0d data=%0d expected all 0",
               bus.fb_write, bus.fb_addr, bus.fb_data);
    end
    vectors++;
    if ({clear_done, fifo_full, overflow, pixel_count} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_status: got done=%0d full=%0d ovf=%0d count=%0d expected all 0",
               clear_done, fifo_full, overflow, pixel_count);
    end
  endtask

  task automatic test_latency();
    logic w; logic [14:0] a; logic [2:0] d;
    apply_reset();
    step(1'b1, 8'd10, 7'd5, 3'b101, 1'b1, 1'b0, w, a, d);
    step(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0, w, a, d);
    vectors++;
    if (w !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_early: got fb_write=%0d expected 0 one cycle after plot", w);
    end
    step(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0, w, a, d);
    vectors++;
    if ({w, a, d} !== {1'b1, 15'd810, 3'd5}) begin
      miscompares++;
      $display("FAIL latency_write: got write=%0d addr=%0d data=%0d expected 1/810/5", w, a, d);
    end
    step(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0, w, a, d);
    vectors++;
    if (w !== 1'b0 || pixel_count !== 16'd1) begin
      miscompares++;
      $display("FAIL latency_single: got write=%0d count=%0d expected 0/1", w, pixel_count);
    end
  endtask

  task automatic test_clip();
    logic w; logic [14:0] a; logic [2:0] d;
    int writes = 0;
    apply_reset();
    step(1'b1, 8'd160, 7'd0, 3'd7, 1'b1, 1'b0, w, a, d);
    step(1'b1, 8'd0, 7'd120, 3'd7, 1'b1, 1'b0, w, a, d);
    step(1'b1, 8'd255, 7'd127, 3'd7, 1'b1, 1'b0, w, a, d);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0, w, a, d);
      if (w) writes++;
    end
    vectors++;
    if (writes !== 0 || overflow !== 1'b0 || pixel_count !== 16'd0) begin
      miscompares++;
      $display("FAIL clip_offscreen: got writes=%0d ovf=%0d count=%0d expected 0/0/0",
               writes, overflow, pixel_count);
    end
    // The last on-screen pixel is the highest legal address.
    step(1'b1, 8'd159, 7'd119, 3'd2, 1'b1, 1'b0, w, a, d);
    step(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0, w, a, d);
    step(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0, w, a, d);
    vectors++;
    if ({w, a, d} !== {1'b1, 15'd19199, 3'd2}) begin
      miscompares++;
      $display("FAIL clip_corner: got write=%0d addr=%0d data=%0d expected 1/19199/2", w, a, d);
    end
  endtask

  task automatic test_overflow();
    logic w; logic [14:0] a; logic [2:0] d;
    logic [14:0] exp_a [10];
    logic [2:0]  exp_d [10];
    int n = 0, first = -1, last = -1;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      exp_a[i] = 15'((i + 3) * WIDTH + i * 7 + 1);
      exp_d[i] = 3'(i);
      step(1'b1, 8'(i * 7 + 1), 7'(i + 3), 3'(i), 1'b0, 1'b0, w, a, d);
      if (i >= 2) begin
        vectors++;
        if ({w, a, d} !== {1'b1, exp_a[0], exp_d[0]}) begin
          miscompares++;
          $display("FAIL stall_hold: cycle %0d got write=%0d addr=%0d data=%0d expected 1/%0d/%0d",
                   i, w, a, d, exp_a[0], exp_d[0]);
        end
      end
    end
    step(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0, w, a, d);
    vectors++;
    if (fifo_full !== 1'b1 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_flags: got full=%0d ovf=%0d expected 1/1", fifo_full, overflow);
    end
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0, w, a, d);
      if (w) begin
        vectors++;
        if (n >= 9 || a !== exp_a[n] || d !== exp_d[n]) begin
          miscompares++;
          $display("FAIL drain_order: write %0d got addr=%0d data=%0d", n, a, d);
        end
        if (first < 0) first = k;
        last = k;
        n++;
      end
    end
    vectors++;
    if (n !== 9 || last - first !== 8) begin
      miscompares++;
      $display("FAIL drain_count: got %0d writes over %0d cycles expected 9 over 9",
               n, last - first + 1);
    end
    vectors++;
    if (overflow !== 1'b1 || fifo_full !== 1'b0 || pixel_count !== 16'd9) begin
      miscompares++;
      $display("FAIL drain_status: got ovf=%0d full=%0d count=%0d expected 1/0/9",
               overflow, fifo_full, pixel_count);
    end
  endtask

  // Runs a clear with optional stalls; optionally injects a plot plus a stray clear_start.
  task automatic run_clear(input bool_stall, input bit with_plot, input string tag);
    logic w; logic [14:0] a; logic [2:0] d;
    logic rdy, pv, clr;
    int next_addr = 0, done_count = 0, plot_writes = 0, after_done = -1;
    apply_reset();
    step(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b1, w, a, d);
    for (int k = 0; k < 25000 && (after_done < 0 || k < after_done + 20); k++) begin
      rdy = bool_stall ? ($urandom_range(7) != 0) : 1'b1;
      pv  = with_plot && (k == 100);
      clr = with_plot && (k == 100);
      step(pv, 8'd3, 7'd2, 3'd6, rdy, clr, w, a, d);
      if (clear_done) begin
        done_count++;
        if (after_done < 0) after_done = k;
        vectors++;
        if (next_addr !== SCREEN) begin
          miscompares++;
          $display("FAIL %s_done_early: got done after %0d writes expected %0d", tag, next_addr, SCREEN);
        end
      end
      if (w && rdy) begin
        vectors++;
        if (after_done < 0) begin
          if (a !== 15'(next_addr) || d !== 3'd0) begin
            miscompares++;
            $display("FAIL %s_sweep: got addr=%0d data=%0d expected %0d/0", tag, a, d, next_addr);
          end
          next_addr++;
        end else begin
          if (!with_plot || a !== 15'd323 || d !== 3'd6) begin
            miscompares++;
            $display("FAIL %s_post: got addr=%0d data=%0d expected 323/6", tag, a, d);
          end
          plot_writes++;
        end
      end
    end
    vectors++;
    if (next_addr !== SCREEN || done_count !== 1) begin
      miscompares++;
      $display("FAIL %s_totals: got writes=%0d done_pulses=%0d expected %0d/1",
               tag, next_addr, done_count, SCREEN);
    end
    vectors++;
    if (plot_writes !== (with_plot ? 1 : 0) || pixel_count !== 16'(with_plot ? 1 : 0)) begin
      miscompares++;
      $display("FAIL %s_plots: got plot_writes=%0d count=%0d expected %0d/%0d",
               tag, plot_writes, pixel_count, with_plot ? 1 : 0, with_plot ? 1 : 0);
    end
  endtask

  task automatic test_clear();
    run_clear(1'b1, 1'b0, "clear");
  endtask

  task automatic test_plot_during_clear();
    run_clear(1'b0, 1'b1, "midclear");
  endtask

  task automatic test_reset_mid_clear();
    logic w; logic [14:0] a; logic [2:0] d;
    bit found = 0;
    int stray = 0;
    apply_reset();
    step(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b1, w, a, d);
    for (int k = 0; k < 1000 && !found; k++) begin
      step(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0, w, a, d);
      if (w && a == 15'd500) found = 1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL abort_reach: sweep did not reach address 500 within budget");
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({bus.fb_write, bus.fb_addr, bus.fb_data, clear_done} !== 20'd0) begin
      miscompares++;
      $display("FAIL abort_async: got write=%0d addr=%0d data=%0d done=%0d expected all 0",
               bus.fb_write, bus.fb_addr, bus.fb_data, clear_done);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0, w, a, d);
      if (w || clear_done) stray++;
    end
    vectors++;
    if (stray !== 0) begin
      miscompares++;
      $display("FAIL abort_quiet: got %0d cycles with write or done expected 0", stray);
    end
    step(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b1, w, a, d);
    for (int k = 0; k < 10 && !w; k++)
      step(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0, w, a, d);
    vectors++;
    if (w !== 1'b1 || a !== 15'd0) begin
      miscompares++;
      $display("FAIL abort_restart: got write=%0d addr=%0d expected 1/0", w, a);
    end
    step(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b0, w, a, d);
    vectors++;
    if (w !== 1'b1 || a !== 15'd1) begin
      miscompares++;
      $display("FAIL abort_second: got write=%0d addr=%0d expected 1/1", w, a);
    end
  endtask

  // Model: every on-screen plot reaches the framebuffer exactly once, in issue order.
  task automatic test_random();
    logic w; logic [14:0] a; logic [2:0] d;
    logic rdy, pv;
    logic [7:0] x; logic [6:0] y; logic [2:0] c;
    logic [17:0] q [$];
    logic [17:0] head;
    int accepted = 0, writes = 0;
    apply_reset();
    for (int k = 0; k < 1600; k++) begin
      rdy = (k >= 1500) || ($urandom_range(3) != 0);
      x   = 8'($urandom_range(170));
      y   = 7'($urandom_range(125));
      c   = 3'($urandom_range(7));
      pv  = (k < 1500) && ($urandom_range(1) == 1);
      // Hold back on-screen plots once the model's backlog could fill the FIFO.
      if (pv && x < WIDTH && y < HEIGHT && q.size() >= FIFO_DEPTH) pv = 1'b0;
      step(pv, x, y, c, rdy, 1'b0, w, a, d);
      if (w && rdy) begin
        vectors++;
        writes++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL random_extra: unexpected write addr=%0d data=%0d", a, d);
        end else begin
          head = q.pop_front();
          if ({a, d} !== head) begin
            miscompares++;
            $display("FAIL random_data: got addr=%0d data=%0d expected %0d/%0d",
                     a, d, head[17:3], head[2:0]);
          end
        end
      end
      if (pv && x < WIDTH && y < HEIGHT) begin
        q.push_back({15'(int'(y) * WIDTH + int'(x)), c});
        accepted++;
      end
    end
    vectors++;
    if (q.size() !== 0 || writes !== accepted) begin
      miscompares++;
      $display("FAIL random_drain: got %0d writes expected %0d (%0d left)", writes, accepted, q.size());
    end
    vectors++;
    if (pixel_count !== 16'(accepted) || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL random_status: got count=%0d ovf=%0d expected %0d/0", pixel_count, overflow, accepted);
    end
  endtask

  initial begin
    bus.vga_write  = 1'b0;
    bus.vga_x      = '0;
    bus.vga_y      = '0;
    bus.vga_colour = '0;
    bus.fb_ready   = 1'b0;
    clear_start    = 1'b0;
    test_reset();
    test_latency();
    test_clip();
    test_overflow();
    test_random();
    test_clear();
    test_plot_during_clear();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
